ysyx_22041211_mem_arbiter: RTL and testbench

Arbitrates the core's single physical-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). One transaction is outstanding at a time, using a valid/ready request handshake on each side. Responses are routed back to the requester that owns the transaction. A watchdog terminates transactions that the memory never answers. The block sits between the fetch/LSU stages and the memory model, which the DPI pmem read/write calls back.

---
 rtl/ysyx_22041211_mem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_ysyx_22041211_mem_arbiter.sv | 448 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_mem_arbiter.sv
// Shares the single physical-memory port between the IFU and the LSU: one outstanding
// transaction, round-robin grant on contention, and a watchdog for responses that never arrive.
module ysyx_22041211_mem_arbiter #(
    parameter int unsigned DATA_LEN    = 32,
    parameter int unsigned ADDR_LEN    = 32,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [ADDR_LEN-1:0] ifu_addr,
    output logic                ifu_resp_valid,
    output logic [DATA_LEN-1:0] ifu_rdata,
    output logic                ifu_resp_err,

    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [ADDR_LEN-1:0] lsu_addr,
    input  logic                lsu_wen,
    input  logic [DATA_LEN-1:0] lsu_wdata,
    input  logic [7:0]          lsu_wmask,
    output logic                lsu_resp_valid,
    output logic [DATA_LEN-1:0] lsu_rdata,
    output logic                lsu_resp_err,

    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic                mem_wen,
    output logic [DATA_LEN-1:0] mem_wdata,
    output logic [7:0]          mem_wmask,
    input  logic                mem_resp_valid,
    input  logic [DATA_LEN-1:0] mem_rdata
);

    // Wide enough to hold TIMEOUT_CYC itself.
    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
    typedef enum logic {OwnIfu = 1'b0, OwnLsu = 1'b1} owner_e;

    state_e              state_q, state_d;
    owner_e              owner_q, owner_d;
    owner_e              last_q, last_d;
    logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;

    logic                mem_req_valid_q, mem_req_valid_d;
    logic [ADDR_LEN-1:0] mem_addr_q, mem_addr_d;
    logic                mem_wen_q, mem_wen_d;
    logic [DATA_LEN-1:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]          mem_wmask_q, mem_wmask_d;

    logic                ifu_resp_valid_q, ifu_resp_valid_d;
    logic [DATA_LEN-1:0] ifu_rdata_q, ifu_rdata_d;
    logic                ifu_resp_err_q, ifu_resp_err_d;
    logic                lsu_resp_valid_q, lsu_resp_valid_d;
    logic [DATA_LEN-1:0] lsu_rdata_q, lsu_rdata_d;
    logic                lsu_resp_err_q, lsu_resp_err_d;

    logic                grant_ifu, grant_lsu;
    logic                resp_fire, resp_err;
    logic [DATA_LEN-1:0] resp_data;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        last_d           = last_q;
        cnt_d            = cnt_q;
        cnt_inc          = cnt_q + 1'b1;
        mem_req_valid_d  = mem_req_valid_q;
        mem_addr_d       = mem_addr_q;
        mem_wen_d        = mem_wen_q;
        mem_wdata_d      = mem_wdata_q;
        mem_wmask_d      = mem_wmask_q;
        ifu_resp_valid_d = 1'b0;
        ifu_rdata_d      = ifu_rdata_q;
        ifu_resp_err_d   = ifu_resp_err_q;
        lsu_resp_valid_d = 1'b0;
        lsu_rdata_d      = lsu_rdata_q;
        lsu_resp_err_d   = lsu_resp_err_q;
        ifu_req_ready    = 1'b0;
        lsu_req_ready    = 1'b0;
        resp_fire        = 1'b0;
        resp_err         = 1'b0;
        resp_data        = {DATA_LEN{1'b0}};

        // On a tie the requester that was not served last wins.
        grant_lsu = lsu_req_valid && (!ifu_req_valid || (last_q == OwnIfu));
        grant_ifu = ifu_req_valid && !grant_lsu;

        case (state_q)
            StIdle: begin
                ifu_req_ready = grant_ifu;
                lsu_req_ready = grant_lsu;
                if (grant_lsu) begin
                    mem_addr_d      = lsu_addr;
                    mem_wen_d       = lsu_wen;
                    mem_wdata_d     = lsu_wdata;
                    mem_wmask_d     = lsu_wmask;
                    mem_req_valid_d = 1'b1;
                    owner_d         = OwnLsu;
                    last_d          = OwnLsu;
                    state_d         = StReq;
                end else if (grant_ifu) begin
                    mem_addr_d      = ifu_addr;
                    mem_wen_d       = 1'b0;
                    mem_wdata_d     = {DATA_LEN{1'b0}};
                    mem_wmask_d     = 8'h0F;
                    mem_req_valid_d = 1'b1;
                    owner_d         = OwnIfu;
                    last_d          = OwnIfu;
                    state_d         = StReq;
                end
            end
            StReq: begin
                if (mem_req_ready) begin
                    mem_req_valid_d = 1'b0;
                    cnt_d           = {CntW{1'b0}};
                    state_d         = StWait;
                end
            end
            StWait: begin
                cnt_d = cnt_inc;
                // A response in the final watchdog cycle still wins over the timeout.
                if (mem_resp_valid) begin
                    resp_fire = 1'b1;
                    resp_data = mem_wen_q ? {DATA_LEN{1'b0}} : mem_rdata;
                end else if (cnt_inc == CntW'(TIMEOUT_CYC)) begin
                    resp_fire = 1'b1;
                    resp_err  = 1'b1;
                end
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (resp_fire) begin
            if (owner_q == OwnIfu) begin
                ifu_resp_valid_d = 1'b1;
                ifu_rdata_d      = resp_data;
                ifu_resp_err_d   = resp_err;
            end else begin
                lsu_resp_valid_d = 1'b1;
                lsu_rdata_d      = resp_data;
                lsu_resp_err_d   = resp_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= StIdle;
            owner_q          <= OwnIfu;
            last_q           <= OwnIfu;
            cnt_q            <= {CntW{1'b0}};
            mem_req_valid_q  <= 1'b0;
            mem_addr_q       <= {ADDR_LEN{1'b0}};
            mem_wen_q        <= 1'b0;
            mem_wdata_q      <= {DATA_LEN{1'b0}};
            mem_wmask_q      <= 8'h00;
            ifu_resp_valid_q <= 1'b0;
            ifu_rdata_q      <= {DATA_LEN{1'b0}};
            ifu_resp_err_q   <= 1'b0;
            lsu_resp_valid_q <= 1'b0;
            lsu_rdata_q      <= {DATA_LEN{1'b0}};
            lsu_resp_err_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_q           <= last_d;
            cnt_q            <= cnt_d;
            mem_req_valid_q  <= mem_req_valid_d;
            mem_addr_q       <= mem_addr_d;
            mem_wen_q        <= mem_wen_d;
            mem_wdata_q      <= mem_wdata_d;
            mem_wmask_q      <= mem_wmask_d;
            ifu_resp_valid_q <= ifu_resp_valid_d;
            ifu_rdata_q      <= ifu_rdata_d;
            ifu_resp_err_q   <= ifu_resp_err_d;
            lsu_resp_valid_q <= lsu_resp_valid_d;
            lsu_rdata_q      <= lsu_rdata_d;
            lsu_resp_err_q   <= lsu_resp_err_d;
        end
    end

    assign mem_req_valid  = mem_req_valid_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wen        = mem_wen_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wmask      = mem_wmask_q;
    assign ifu_resp_valid = ifu_resp_valid_q;
    assign ifu_rdata      = ifu_rdata_q;
    assign ifu_resp_err   = ifu_resp_err_q;
    assign lsu_resp_valid = lsu_resp_valid_q;
    assign lsu_rdata      = lsu_rdata_q;
    assign lsu_resp_err   = lsu_resp_err_q;

endmodule

// File: tb/tb_ysyx_22041211_mem_arbiter.sv
// Bench for the IFU/LSU memory arbiter: directed scenarios plus a randomized run checked
// against a transaction-level model of grant order, response routing and timeout.
module tb_ysyx_22041211_mem_arbiter;
    localparam int TO = 4;

    logic        clk, rst;
    logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
    logic [31:0] ifu_addr, ifu_rdata;
    logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
    logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
    logic [7:0]  lsu_wmask;
    logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [7:0]  mem_wmask;

    ysyx_22041211_mem_arbiter #(.DATA_LEN(32), .ADDR_LEN(32), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
        .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Memory responder: fixed or random stall before ready, response d cycles after handshake
    // (d = 0 means the memory never answers).
    bit          mem_pend, rand_mem, force_resp;
    int          mem_wait, fix_delay, stall_left;
    logic [31:0] mem_pend_addr;

    // Per-cycle observation, sampled one unit after the falling edge.
    logic        o_ifu_ready, o_lsu_ready, o_mreq, o_mwen, o_irv, o_ierr, o_lrv, o_lerr;
    logic [31:0] o_maddr, o_mwdata, o_ird, o_lrd;
    logic [7:0]  o_mwmask;
    bit          o_hs;
    int          o_hs_delay;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'h8000_0000) return 32'h0010_0073;
        return (a ^ 32'h5A5A_1234) | 32'h1;
    endfunction

    task automatic step();
        mem_resp_valid = 1'b0;
        mem_rdata      = 32'h0;
        mem_req_ready  = 1'b0;
        o_hs           = 1'b0;
        if (force_resp) begin
            mem_resp_valid = 1'b1;
            mem_rdata      = 32'hBAD0_0BAD;
            force_resp     = 1'b0;
        end
        if (mem_pend) begin
            mem_wait--;
            if (mem_wait == 0) begin
                mem_resp_valid = 1'b1;
                mem_rdata      = mem_fn(mem_pend_addr);
                mem_pend       = 1'b0;
            end
        end
        if (mem_req_valid && !mem_pend) begin
            if (stall_left > 0) begin
                stall_left--;
            end else begin
                mem_req_ready = 1'b1;
                o_hs          = 1'b1;
                o_hs_delay    = rand_mem ? int'($urandom_range(1, TO + 2)) : fix_delay;
                if (o_hs_delay > 0) begin
                    mem_pend      = 1'b1;
                    mem_wait      = o_hs_delay;
                    mem_pend_addr = mem_addr;
                end
                if (rand_mem) stall_left = int'($urandom_range(0, 2));
            end
        end
        #1;
        o_ifu_ready = ifu_req_ready;  o_lsu_ready = lsu_req_ready;
        o_mreq  = mem_req_valid;      o_maddr  = mem_addr;   o_mwen = mem_wen;
        o_mwdata = mem_wdata;         o_mwmask = mem_wmask;
        o_irv = ifu_resp_valid;       o_ird = ifu_rdata;     o_ierr = ifu_resp_err;
        o_lrv = lsu_resp_valid;       o_lrd = lsu_rdata;     o_lerr = lsu_resp_err;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        ifu_req_valid = 0; ifu_addr = 0;
        lsu_req_valid = 0; lsu_addr = 0; lsu_wen = 0; lsu_wdata = 0; lsu_wmask = 0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
        mem_pend = 0; force_resp = 0; rand_mem = 0; stall_left = 0; fix_delay = 1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        #3 rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== 74'h0) begin
            n_fail++;
            $display("FAIL reset_mem: got %h required 0",
                     {mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask});
        end
        n_tests++;
        if ({ifu_resp_valid, ifu_rdata, ifu_resp_err, lsu_resp_valid, lsu_rdata, lsu_resp_err}
            !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_resp: got %h required 0", {ifu_resp_valid, ifu_rdata,
                     ifu_resp_err, lsu_resp_valid, lsu_rdata, lsu_resp_err});
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        step();
        n_tests++;
        if ({o_ifu_ready, o_lsu_ready} !== 2'b00) begin
            n_fail++;
            $display("FAIL idle_ready: got %b required 00", {o_ifu_ready, o_lsu_ready});
        end
    endtask

    task automatic test_single_fetch();
        int pulses, lsu_p, at;
        apply_reset();
        fix_delay = 2;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0000;
        step();
        n_tests++;
        if ({o_ifu_ready, o_lsu_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL fetch_ready: got %b required 10", {o_ifu_ready, o_lsu_ready});
        end
        ifu_req_valid = 0; ifu_addr = 32'h0;
        step();
        n_tests++;
        if ({o_mreq, o_maddr, o_mwen, o_mwdata, o_mwmask} !== {1'b1, 32'h8000_0000, 1'b0,
            32'h0, 8'h0F}) begin
            n_fail++;
            $display("FAIL fetch_mem: got %h required %h", {o_mreq, o_maddr, o_mwen, o_mwdata,
                     o_mwmask}, {1'b1, 32'h8000_0000, 1'b0, 32'h0, 8'h0F});
        end
        pulses = 0; lsu_p = 0; at = -1;
        for (int i = 0; i < 6; i++) begin
            step();
            if (o_lrv) lsu_p++;
            if (o_irv) begin
                pulses++; at = i;
                n_tests++;
                if ({o_ird, o_ierr} !== {32'h0010_0073, 1'b0}) begin
                    n_fail++;
                    $display("FAIL fetch_data: got %h/%b required 00100073/0", o_ird, o_ierr);
                end
            end
        end
        n_tests++;
        if (pulses !== 1 || at !== 2 || lsu_p !== 0) begin
            n_fail++;
            $display("FAIL fetch_pulse: got n=%0d at=%0d lsu=%0d required n=1 at=2 lsu=0",
                     pulses, at, lsu_p);
        end
    endtask

    task automatic test_store();
        int pulses, at;
        logic [72:0] exp_f;
        exp_f = {32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 8'h03};
        fix_delay = 1; stall_left = 3;
        lsu_req_valid = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h03;
        step();
        n_tests++;
        if ({o_ifu_ready, o_lsu_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL store_ready: got %b required 01", {o_ifu_ready, o_lsu_ready});
        end
        lsu_req_valid = 0; lsu_wen = 0; lsu_addr = 0; lsu_wdata = 0; lsu_wmask = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_tests++;
            if ({o_mreq, o_maddr, o_mwen, o_mwdata, o_mwmask} !== {1'b1, exp_f}) begin
                n_fail++;
                $display("FAIL store_hold[%0d]: got %h required %h", i,
                         {o_mreq, o_maddr, o_mwen, o_mwdata, o_mwmask}, {1'b1, exp_f});
            end
        end
        pulses = 0; at = -1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (o_lrv) begin
                pulses++; at = i;
                n_tests++;
                if ({o_lrd, o_lerr} !== 33'h0) begin
                    n_fail++;
                    $display("FAIL store_data: got %h/%b required 0/0", o_lrd, o_lerr);
                end
            end
        end
        n_tests++;
        if (pulses !== 1 || at !== 1) begin
            n_fail++;
            $display("FAIL store_pulse: got n=%0d at=%0d required n=1 at=1", pulses, at);
        end
    endtask

    task automatic test_random();
        int          m_last, own, acc_k, resp_k, d;
        bit          busy, hs_done, exp_gi, exp_gl, exp_i, exp_l, exp_mreq;
        logic        t_wen, exp_err;
        logic [31:0] t_addr, t_wdata, exp_rd;
        logic [7:0]  t_wmask;
        apply_reset();
        rand_mem = 1;
        m_last = 0; busy = 0; hs_done = 0; own = 0; acc_k = 0; resp_k = 0;
        for (int k = 0; k < 400; k++) begin
            if (k < 380) begin
                if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
                    ifu_req_valid = 1; ifu_addr = {$urandom, 2'b00} ;
                end
                if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
                    lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom);
                    lsu_wdata = $urandom; lsu_wmask = 8'($urandom);
                end
            end
            step();
            exp_i = busy && hs_done && (k == resp_k) && (own == 0);
            exp_l = busy && hs_done && (k == resp_k) && (own == 1);
            n_tests++;
            if ({o_irv, o_lrv} !== {exp_i, exp_l}) begin
                n_fail++;
                $display("FAIL rnd_pulse k=%0d: got %b required %b", k, {o_irv, o_lrv},
                         {exp_i, exp_l});
            end
            if (exp_i || exp_l) begin
                n_tests++;
                if ((exp_i ? {o_ird, o_ierr} : {o_lrd, o_lerr}) !== {exp_rd, exp_err}) begin
                    n_fail++;
                    $display("FAIL rnd_data k=%0d: got %h required %h", k,
                             exp_i ? {o_ird, o_ierr} : {o_lrd, o_lerr}, {exp_rd, exp_err});
                end
                busy = 0;
            end
            exp_gl = !busy && lsu_req_valid && (!ifu_req_valid || m_last == 0);
            exp_gi = !busy && ifu_req_valid && !exp_gl;
            exp_mreq = busy && !hs_done && (k > acc_k);
            n_tests++;
            if ({o_ifu_ready, o_lsu_ready, o_mreq} !== {exp_gi, exp_gl, exp_mreq}) begin
                n_fail++;
                $display("FAIL rnd_ready k=%0d: got %b required %b", k,
                         {o_ifu_ready, o_lsu_ready, o_mreq}, {exp_gi, exp_gl, exp_mreq});
            end
            if (exp_mreq && o_mreq) begin
                n_tests++;
                if ({o_maddr, o_mwen, o_mwdata, o_mwmask} !== {t_addr, t_wen, t_wdata, t_wmask})
                begin
                    n_fail++;
                    $display("FAIL rnd_mem k=%0d: got %h required %h", k, {o_maddr, o_mwen,
                             o_mwdata, o_mwmask}, {t_addr, t_wen, t_wdata, t_wmask});
                end
                if (o_hs) begin
                    hs_done = 1;
                    d       = o_hs_delay;
                    resp_k  = k + ((d <= TO) ? d : TO) + 1;
                    exp_err = (d > TO);
                    exp_rd  = (exp_err || t_wen) ? 32'h0 : mem_fn(t_addr);
                end
            end
            if (exp_gl || exp_gi) begin
                busy = 1; hs_done = 0; acc_k = k;
                own = exp_gl ? 1 : 0; m_last = own;
                if (exp_gl) begin
                    t_addr = lsu_addr; t_wen = lsu_wen; t_wdata = lsu_wdata; t_wmask = lsu_wmask;
                    lsu_req_valid = 0;
                end else begin
                    t_addr = ifu_addr; t_wen = 0; t_wdata = 0; t_wmask = 8'h0F;
                    ifu_req_valid = 0;
                end
            end
        end
        rand_mem = 0;
    endtask

    task automatic test_timeout();
        int pulses, ipulses, at;
        fix_delay = 1;
        lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000;
        step();
        lsu_req_valid = 0;
        repeat (5) step();
        n_tests++;
        if ({o_lrd, o_lerr} !== {mem_fn(32'h8000_3000), 1'b0}) begin
            n_fail++;
            $display("FAIL warm_load: got %h required %h", {o_lrd, o_lerr},
                     {mem_fn(32'h8000_3000), 1'b0});
        end
        fix_delay = 0;
        lsu_req_valid = 1; lsu_addr = 32'h8000_2000;
        step();
        lsu_req_valid = 0;
        step();
        pulses = 0; ipulses = 0; at = -1;
        for (int i = 0; i < 10; i++) begin
            if (i == 6) force_resp = 1;
            step();
            if (o_irv) ipulses++;
            if (o_lrv) begin
                pulses++; at = i;
                n_tests++;
                if ({o_lrd, o_lerr} !== {32'h0, 1'b1}) begin
                    n_fail++;
                    $display("FAIL timeout_data: got %h/%b required 0/1", o_lrd, o_lerr);
                end
            end
        end
        n_tests++;
        if (pulses !== 1 || at !== 4 || ipulses !== 0) begin
            n_fail++;
            $display("FAIL timeout_pulse: got n=%0d at=%0d ifu=%0d required n=1 at=4 ifu=0",
                     pulses, at, ipulses);
        end
    endtask

    task automatic test_contention();
        int grants[$];
        int owners[$];
        logic [31:0] addrs[$];
        int nresp, o;
        logic [31:0] a;
        apply_reset();
        fix_delay = 1;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0100;
        lsu_req_valid = 1; lsu_addr = 32'h8000_0800; lsu_wen = 0;
        nresp = 0;
        for (int k = 0; k < 40 && grants.size() < 4; k++) begin
            step();
            n_tests++;
            if (o_ifu_ready === 1'b1 && o_lsu_ready === 1'b1) begin
                n_fail++;
                $display("FAIL both_ready k=%0d: got 11 required at most one", k);
            end
            if (o_irv || o_lrv) begin
                o = owners.pop_front();
                a = addrs.pop_front();
                nresp++;
                n_tests++;
                if ({o_irv, o_lrv} !== ((o == 0) ? 2'b10 : 2'b01) ||
                    ((o == 0) ? o_ird : o_lrd) !== mem_fn(a)) begin
                    n_fail++;
                    $display("FAIL cont_route: got %b/%h required owner %0d data %h",
                             {o_irv, o_lrv}, (o == 0) ? o_ird : o_lrd, o, mem_fn(a));
                end
            end
            if (o_lsu_ready) begin
                grants.push_back(1); owners.push_back(1); addrs.push_back(lsu_addr);
                lsu_addr += 4;
            end else if (o_ifu_ready) begin
                grants.push_back(0); owners.push_back(0); addrs.push_back(ifu_addr);
                ifu_addr += 4;
            end
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        n_tests++;
        if (grants.size() != 4 || grants[0] != 1 || grants[1] != 0 || grants[2] != 1 ||
            grants[3] != 0 || nresp != 3) begin
            n_fail++;
            $display("FAIL cont_order: got %0d grants %p, %0d responses required LSU,IFU,LSU,IFU",
                     grants.size(), grants, nresp);
        end
        repeat (6) step();
    endtask

    task automatic test_reset_mid_wait();
        int pulses;
        fix_delay = 0;
        ifu_req_valid = 1; ifu_addr = 32'h8000_0040;
        step();
        ifu_req_valid = 0;
        step();
        step();
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({mem_req_valid, mem_addr, mem_wmask, ifu_resp_valid, ifu_rdata, lsu_resp_valid,
             lsu_rdata, ifu_req_ready, lsu_req_ready} !== 109'h0) begin
            n_fail++;
            $display("FAIL async_reset: got %h required 0", {mem_req_valid, mem_addr, mem_wmask,
                     ifu_resp_valid, ifu_rdata, lsu_resp_valid, lsu_rdata});
        end
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        force_resp = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (o_irv || o_lrv || o_mreq) pulses++;
        end
        n_tests++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL stale_resp: got %0d activity cycles required 0", pulses);
        end
        fix_delay = 1;
        ifu_req_valid = 1; lsu_req_valid = 1; lsu_wen = 0; lsu_addr = 32'h8000_0080;
        step();
        n_tests++;
        if ({o_ifu_ready, o_lsu_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL post_reset_grant: got %b required 01", {o_ifu_ready, o_lsu_ready});
        end
        ifu_req_valid = 0; lsu_req_valid = 0;
        repeat (5) step();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_random();
        test_timeout();
        test_contention();
        test_reset_mid_wait();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
